imm_extend_unit: RTL and testbench
==================================

# imm_extend_unit

Parametrised, pipelined immediate-extension unit for the processor's decode stage. Accepts an IN_W-bit immediate with a 2-bit mode and a destination tag, and produces an OUT_W-bit sign-extended, zero-extended, upper-placed or branch-scaled operand. Both sides use a valid/ready handshake, and a two-entry skid buffer keeps throughput at one result per clock under backpressure. Downstream consumers are the ALU operand mux and the branch-target adder.

## Interface
- IN_W, 16, immediate input width; legal range 2 ≤ IN_W ≤ OUT_W-2
- OUT_W, 32, result width
- TAG_W, 5, passthrough tag width (destination register id)
- clock  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_imm/in_mode/in_tag valid this cycle
- in_ready  output  1  unit can accept; registered
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  00 sign-ext, 01 zero-ext, 10 upper, 11 branch (sign-ext, shift left 2)
- in_tag  input  TAG_W  carried unchanged to out_tag
- out_valid  output  1  out_data/out_tag valid
- out_ready  input  1  consumer accepts this cycle
- out_data  output  OUT_W  extended result; registered
- out_tag  output  TAG_W  tag of the result; registered

## Operation
- Transfer in: in_valid && in_ready on a rising edge. Transfer out: out_valid && out_ready on a rising edge.
- Arithmetic, computed combinationally on the input side and registered:
  - mode 00: upper OUT_W-IN_W bits = in_imm[IN_W-1], low IN_W bits = in_imm.
  - mode 01: upper bits = 0, low IN_W bits = in_imm.
  - mode 10: in_imm in bits [OUT_W-1 : OUT_W-IN_W]; lower bits = 0.
  - mode 11: mode-00 value shifted left 2, bits [1:0] = 0, upper 2 bits discarded.
- An X/Z on in_imm[IN_W-1] is not detected. It propagates as X through the upper bits in modes 00 and 11; the low IN_W bits pass unchanged.
- Storage: output register (OR) drives out_*; skid register (SR) holds one entry.
- States: EMPTY (OR and SR empty), ONE (OR full, SR empty), FULL (OR and SR full).
  - EMPTY: input transfer → ONE; the result is loaded into OR.
  - ONE, input only: if out_ready, stay ONE and load OR with the new result; else → FULL, result into SR.
  - ONE, output only → EMPTY.
  - ONE, both transfers → ONE; OR takes the new result.
  - FULL: in_ready=0. On output transfer, OR takes SR and the state → ONE. No input is accepted in FULL.
- in_ready is registered: 1 in EMPTY and ONE, 0 in FULL. It drops in the cycle after SR fills and rises in the cycle after SR drains.
- Ordering is strictly FIFO. Tag always travels with its data.
- Reset, which overrides all activity including a transfer in the same cycle:
  - out_valid=0, out_data=0, out_tag=0, in_ready=1.
  - SR is emptied and state → EMPTY.
  - In-flight entries are discarded.

## Timing
- Latency: 1 cycle. An input accepted at edge N appears on out_* after edge N with out_valid=1, provided OR was empty or drained at edge N.
- Throughput: 1 result/cycle while out_ready=1 continuously.
- Backpressure: at most 2 entries buffered; the entry accepted while OR is stalled is never lost.
- out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Test plan
- Defaults, out_ready=1. Inputs 0x8001 in modes 00/01/10/11 on consecutive cycles. Outputs one cycle later, in order: 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004; out_valid high 4 cycles.
- Mode 11 with 0xFFFF → 0xFFFFFFFC. Mode 00 with 0x7FFF → 0x00007FFF. Mode 10 with 0x1234 → 0x12340000.
- Backpressure:
  - Hold out_ready=0 and stream tags 1,2,3.
  - Tags 1,2 are accepted; in_ready goes 0 the cycle after tag 2 is accepted; tag 3 is held.
  - Raise out_ready. Outputs tags 1,2,3 in order with no drop or duplicate, and in_ready returns to 1.
- Simultaneous in/out transfer in ONE: state stays ONE, in_ready stays 1, and the new data appears on the next cycle.
- Reset asserted in FULL for one cycle: next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1, and no pre-reset entry ever emerges.
- Parameter sweep IN_W=12, OUT_W=32, TAG_W=3: 0x800 mode 00 → 0xFFFFF800; 0xABC mode 10 → 0xABC00000.

Source files
------------

// File: rtl/imm_extend_unit.sv
// Immediate-extension unit: sign/zero/upper/branch extension of a decode-stage immediate,
// registered behind a two-entry skid buffer with valid/ready on both sides.
module imm_extend_unit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PadW = OUT_W - IN_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;

  logic             in_ready_q, out_valid_q;
  logic [OUT_W-1:0] or_data_q, sr_data_q;
  logic [TAG_W-1:0] or_tag_q, sr_tag_q;

  logic             in_fire, out_fire;
  logic             or_load, or_from_sr, sr_load;
  logic [OUT_W-1:0] sign_ext, ext_data;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;
  assign out_tag   = or_tag_q;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  assign sign_ext = {{PadW{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    unique case (in_mode)
      2'b00: ext_data = sign_ext;
      2'b01: ext_data = {{PadW{1'b0}}, in_imm};
      2'b10: ext_data = {in_imm, {PadW{1'b0}}};
      2'b11: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
      default: ext_data = '0;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (in_fire) state_d = StOne;
      StOne: begin
        if (in_fire && !out_fire)      state_d = StFull;
        else if (!in_fire && out_fire) state_d = StEmpty;
      end
      StFull:  if (out_fire) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Datapath control
  always_comb begin
    or_load    = 1'b0;
    or_from_sr = 1'b0;
    sr_load    = 1'b0;
    unique case (state_q)
      StEmpty: or_load = in_fire;
      StOne: begin
        or_load = in_fire && out_fire;
        sr_load = in_fire && !out_fire;
      end
      StFull: begin
        or_load    = out_fire;
        or_from_sr = 1'b1;
      end
      default: ;
    endcase
  end

  // Flags are derived from the next state so they are registered yet track occupancy exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      or_data_q   <= '0;
      or_tag_q    <= '0;
      sr_data_q   <= '0;
      sr_tag_q    <= '0;
    end else begin
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      if (or_load) begin
        or_data_q <= or_from_sr ? sr_data_q : ext_data;
        or_tag_q  <= or_from_sr ? sr_tag_q : in_tag;
      end
      if (sr_load) begin
        sr_data_q <= ext_data;
        sr_tag_q  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: directed and random traffic against an occupancy/FIFO model,
// plus a narrow-parameter instance.
module tb_imm_extend_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0, out_tag;
  logic [31:0] out_data;

  logic        in_valid2 = 1'b0, in_ready2, out_valid2;
  logic [11:0] in_imm2 = '0;
  logic [1:0]  in_mode2 = '0;
  logic [2:0]  in_tag2 = '0, out_tag2;
  logic [31:0] out_data2;

  always #5 clock = ~clock;

  imm_extend_unit dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(32), .TAG_W(3)) dut2 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
    .in_tag(in_tag2), .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
    .out_tag(out_tag2)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } ent_t;

  ent_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  // Reference extension using integer arithmetic on the immediate's numeric value.
  function automatic logic [31:0] model(input int inw, input logic [31:0] imm,
                                        input logic [1:0] mode);
    longint s, r;
    s = longint'(imm);
    if (s >= (64'sd1 <<< (inw - 1))) s = s - (64'sd1 <<< inw);
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * (64'sd1 <<< (32 - inw));
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock of traffic; flags and head-of-queue data are checked before the edge.
  task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic ordy);
    bit   acc, pop;
    ent_t e;
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    @(negedge clock);
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    if (pop) begin
      e = q.pop_front();
      chk("out_data", out_data, e.d);
      chk("out_tag", {27'd0, out_tag}, {27'd0, e.t});
    end
    if (acc) begin
      e.d = model(16, {16'd0, imm}, mode);
      e.t = tag;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Four modes back to back on 0x8001.
    step(1'b1, 16'h8001, 2'd0, 5'd1, 1'b1);
    chk("m00_8001", out_data, 32'hFFFF8001);
    step(1'b1, 16'h8001, 2'd1, 5'd2, 1'b1);
    chk("m01_8001", out_data, 32'h00008001);
    step(1'b1, 16'h8001, 2'd2, 5'd3, 1'b1);
    chk("m10_8001", out_data, 32'h80010000);
    step(1'b1, 16'h8001, 2'd3, 5'd4, 1'b1);
    chk("m11_8001", out_data, 32'hFFFE0004);
    chk("m11_tag", {27'd0, out_tag}, 32'd4);
    step(1'b1, 16'hFFFF, 2'd3, 5'd5, 1'b1);
    chk("m11_ffff", out_data, 32'hFFFFFFFC);
    step(1'b1, 16'h7FFF, 2'd0, 5'd6, 1'b1);
    chk("m00_7fff", out_data, 32'h00007FFF);
    step(1'b1, 16'h1234, 2'd2, 5'd7, 1'b1);
    chk("m10_1234", out_data, 32'h12340000);
    chk("both_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits.
    step(1'b1, 16'h0011, 2'd0, 5'd1, 1'b0);
    step(1'b1, 16'h0022, 2'd1, 5'd2, 1'b0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step(1'b1, 16'h0033, 2'd2, 5'd3, 1'b0);
    chk("bp_hold_tag1", {27'd0, out_tag}, 32'd1);
    step(1'b1, 16'h0033, 2'd2, 5'd3, 1'b1);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    step(1'b1, 16'h0033, 2'd2, 5'd3, 1'b1);
    chk("bp_tag3_data", out_data, 32'h00330000);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while full discards both entries.
    step(1'b1, 16'hAAAA, 2'd0, 5'd9, 1'b0);
    step(1'b1, 16'hBBBB, 2'd0, 5'd10, 1'b0);
    do_reset();
    chk("frst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("frst_out_data", out_data, 32'd0);
    chk("frst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("frst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);

    // Narrow instance.
    in_valid2 = 1'b1;
    in_imm2   = 12'h800;
    in_mode2  = 2'd0;
    in_tag2   = 3'd5;
    @(posedge clock);
    #1;
    chk("w12_m00_800", out_data2, 32'hFFFFF800);
    chk("w12_tag", {29'd0, out_tag2}, 32'd5);
    in_imm2  = 12'hABC;
    in_mode2 = 2'd2;
    @(posedge clock);
    #1;
    chk("w12_m10_abc", out_data2, 32'hABC00000);
    in_valid2 = 1'b0;

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom_range(0, 3)),
           5'($urandom()), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
